// File: rtl/pmu_quota_mc.sv
// pmu_quota_mc: multi-core PMU quota monitor.
// One shared scan sequencer walks the counter bank; every core accumulates its
// masked counters in parallel, and each completed, consistent scan publishes a
// sum and may raise that core's sticky quota interrupt.
module pmu_quota_mc #(
    parameter  int unsigned REG_WIDTH  = 32,
    parameter  int unsigned N_COUNTERS = 24,
    parameter  int unsigned N_CORES    = 4,
    localparam int unsigned SUM_WIDTH  = REG_WIDTH + $clog2(N_COUNTERS),
    localparam int unsigned ST_W       = $clog2(N_COUNTERS + 1)
) (
    input  logic                                    clk_i,
    input  logic                                    rstn_i,
    input  logic                                    softrst_i,
    input  logic [N_COUNTERS-1:0][REG_WIDTH-1:0]    counter_value_i,
    input  logic [N_CORES-1:0][N_COUNTERS-1:0]      quota_mask_i,
    input  logic [N_CORES-1:0][SUM_WIDTH-1:0]       quota_limit_i,
    input  logic [N_CORES-1:0]                      intr_clear_i,
    output logic [N_CORES-1:0]                      intr_quota_o,
    output logic [N_CORES-1:0][SUM_WIDTH-1:0]       quota_sum_o,
    output logic                                    scan_done_o
);

    // Scan state: 0 is the publish/clear slot, s in 1..N_COUNTERS samples counter s-1.
    localparam logic [ST_W-1:0] ST_PUBLISH = '0;

    logic [ST_W-1:0]                        st_q;
    logic [ST_W-1:0]                        st_d;
    logic [N_CORES-1:0][SUM_WIDTH-1:0]      acc_q;
    logic [N_CORES-1:0][SUM_WIDTH-1:0]      acc_d;
    logic [N_CORES-1:0][N_COUNTERS-1:0]     old_mask_q;
    logic [N_CORES-1:0]                     dirty_q;
    logic [N_CORES-1:0]                     dirty_d;
    logic [N_CORES-1:0][SUM_WIDTH-1:0]      sum_d;
    logic [N_CORES-1:0]                     intr_d;
    logic                                   done_d;

    logic                                   st_pub;
    logic                                   st_chk;
    logic [REG_WIDTH-1:0]                   cnt_sel;
    logic [N_CORES-1:0]                     mask_sel;
    logic [N_CORES-1:0]                     intr_set;

    // Next-state and datapath: sequencer advance, counter select, accumulate, publish.
    always_comb begin
        st_d     = ST_PUBLISH;
        acc_d    = acc_q;
        dirty_d  = dirty_q;
        sum_d    = quota_sum_o;
        intr_d   = intr_quota_o;
        intr_set = '0;
        cnt_sel  = '0;
        mask_sel = '0;

        st_pub = (st_q == ST_PUBLISH);
        // Mask changes only corrupt a scan once at least one counter was summed with the old mask.
        st_chk = (32'(st_q) >= 32'd2) && (32'(st_q) <= N_COUNTERS);

        // Wrap at the last counter; any stray value also recovers to the publish slot.
        if (32'(st_q) < N_COUNTERS) begin
            st_d = st_q + ST_W'(1);
        end

        for (int unsigned j = 0; j < N_COUNTERS; j++) begin
            if (32'(st_q) == j + 32'd1) begin
                cnt_sel = counter_value_i[j];
                for (int unsigned k = 0; k < N_CORES; k++) begin
                    mask_sel[k] = quota_mask_i[k][j];
                end
            end
        end

        for (int unsigned k = 0; k < N_CORES; k++) begin
            if (st_pub) begin
                acc_d[k]   = '0;
                dirty_d[k] = 1'b0;
                if (!dirty_q[k]) begin
                    sum_d[k]    = acc_q[k];
                    intr_set[k] = (acc_q[k] > quota_limit_i[k]);
                end
            end else begin
                acc_d[k]   = acc_q[k] + (mask_sel[k] ? SUM_WIDTH'(cnt_sel) : SUM_WIDTH'(0));
                dirty_d[k] = dirty_q[k] | (st_chk && (old_mask_q[k] != quota_mask_i[k]));
            end
            // Sticky: a set in the same cycle as a clear wins.
            intr_d[k] = (intr_quota_o[k] & ~intr_clear_i[k]) | intr_set[k];
        end

        done_d = st_pub;
    end

    // State and output registers; soft reset mirrors the async reset and overrides all updates.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            st_q         <= ST_PUBLISH;
            acc_q        <= '0;
            old_mask_q   <= '0;
            dirty_q      <= '0;
            quota_sum_o  <= '0;
            intr_quota_o <= '0;
            scan_done_o  <= 1'b0;
        end else if (softrst_i) begin
            st_q         <= ST_PUBLISH;
            acc_q        <= '0;
            old_mask_q   <= '0;
            dirty_q      <= '0;
            quota_sum_o  <= '0;
            intr_quota_o <= '0;
            scan_done_o  <= 1'b0;
        end else begin
            st_q         <= st_d;
            acc_q        <= acc_d;
            old_mask_q   <= quota_mask_i;
            dirty_q      <= dirty_d;
            quota_sum_o  <= sum_d;
            intr_quota_o <= intr_d;
            scan_done_o  <= done_d;
        end
    end

endmodule

// File: tb/tb_pmu_quota_mc.sv
// Directed bench for pmu_quota_mc (REG_WIDTH=8, N_COUNTERS=4, N_CORES=2, SUM_WIDTH=10).
module tb_pmu_quota_mc;

    localparam int unsigned REG_WIDTH  = 8;
    localparam int unsigned N_COUNTERS = 4;
    localparam int unsigned N_CORES    = 2;
    localparam int unsigned SUM_WIDTH  = 10;

    logic                                 clk_i;
    logic                                 rstn_i;
    logic                                 softrst_i;
    logic [N_COUNTERS-1:0][REG_WIDTH-1:0] counter_value;
    logic [N_CORES-1:0][N_COUNTERS-1:0]   quota_mask;
    logic [N_CORES-1:0][SUM_WIDTH-1:0]    quota_limit;
    logic [N_CORES-1:0]                   intr_clear;
    logic [N_CORES-1:0]                   intr_quota;
    logic [N_CORES-1:0][SUM_WIDTH-1:0]    quota_sum;
    logic                                 scan_done;

    int n_checks;
    int n_errors;

    pmu_quota_mc #(
        .REG_WIDTH  (REG_WIDTH),
        .N_COUNTERS (N_COUNTERS),
        .N_CORES    (N_CORES)
    ) dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .softrst_i       (softrst_i),
        .counter_value_i (counter_value),
        .quota_mask_i    (quota_mask),
        .quota_limit_i   (quota_limit),
        .intr_clear_i    (intr_clear),
        .intr_quota_o    (intr_quota),
        .quota_sum_o     (quota_sum),
        .scan_done_o     (scan_done)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance n clock edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rstn_i    = 1'b0;
        softrst_i = 1'b0;
        intr_clear = '0;
        for (int j = 0; j < int'(N_COUNTERS); j++) counter_value[j] = 8'hFF;
        quota_mask[0]  = 4'hF;
        quota_mask[1]  = 4'hF;
        quota_limit[0] = 10'd1019;
        quota_limit[1] = 10'd1020;

        // Reset state
        step(3);
        check_val("rst_sum0", 32'(quota_sum[0]), 32'd0);
        check_val("rst_intr", 32'(intr_quota), 32'd0);
        check_val("rst_done", 32'(scan_done), 32'd0);
        rstn_i = 1'b1;

        // E0: first publish of an empty accumulator
        step(1);
        check_val("e0_done", 32'(scan_done), 32'd1);
        check_val("e0_sum0", 32'(quota_sum[0]), 32'd0);

        // Boundary compare: 4*255 = 1020; strictly above 1019 only
        for (int i = 1; i <= 10; i++) begin
            step(1);
            check_val($sformatf("done_e%0d", i), 32'(scan_done), (i % 5 == 0) ? 32'd1 : 32'd0);
            if (i == 5) begin
                check_val("bnd_sum0", 32'(quota_sum[0]), 32'd1020);
                check_val("bnd_sum1", 32'(quota_sum[1]), 32'd1020);
                check_val("bnd_intr", 32'(intr_quota), 32'd1);
            end
        end

        // Clear while over limit, then re-assert at next publish
        step(1);
        intr_clear = 2'b01;
        step(1);
        intr_clear = 2'b00;
        check_val("clr_drop", 32'(intr_quota), 32'd0);
        step(3);
        check_val("clr_reassert", 32'(intr_quota), 32'd1);

        // Clear in the publish cycle loses against the set
        step(4);
        intr_clear = 2'b01;
        step(1);
        intr_clear = 2'b00;
        check_val("set_wins", 32'(intr_quota), 32'd1);

        // Soft reset at st=2 with interrupt set; load masking vectors meanwhile
        step(1);
        softrst_i = 1'b1;
        counter_value[0] = 8'd10;
        counter_value[1] = 8'd20;
        counter_value[2] = 8'd30;
        counter_value[3] = 8'd40;
        quota_mask[0]  = 4'b0101;
        quota_mask[1]  = 4'b1010;
        quota_limit[0] = 10'd100;
        quota_limit[1] = 10'd100;
        step(1);
        softrst_i = 1'b0;
        check_val("srst_intr", 32'(intr_quota), 32'd0);
        check_val("srst_sum0", 32'(quota_sum[0]), 32'd0);
        check_val("srst_sum1", 32'(quota_sum[1]), 32'd0);
        check_val("srst_done", 32'(scan_done), 32'd0);
        step(1);
        check_val("srst_restart_done", 32'(scan_done), 32'd1);

        // Per-core masking: 10+30 and 20+40
        step(5);
        check_val("mask_sum0", 32'(quota_sum[0]), 32'd40);
        check_val("mask_sum1", 32'(quota_sum[1]), 32'd60);
        check_val("mask_intr", 32'(intr_quota), 32'd0);
        check_val("mask_done", 32'(scan_done), 32'd1);
        quota_mask[0] = 4'b0001;

        // Change applied at st=1 is consistent for the whole scan
        step(5);
        check_val("m1_sum0", 32'(quota_sum[0]), 32'd10);
        check_val("m1_sum1", 32'(quota_sum[1]), 32'd60);

        // Dirty discard: core0 mask changes at st=3
        step(2);
        quota_mask[0] = 4'hF;
        step(3);
        check_val("dirty_sum0", 32'(quota_sum[0]), 32'd10);
        check_val("dirty_sum1", 32'(quota_sum[1]), 32'd60);
        check_val("dirty_done", 32'(scan_done), 32'd1);
        quota_limit[0] = 10'd50;
        step(5);
        check_val("full_sum0", 32'(quota_sum[0]), 32'd100);
        check_val("full_sum1", 32'(quota_sum[1]), 32'd60);
        check_val("full_intr", 32'(intr_quota), 32'd1);

        // Asynchronous reset between edges
        #3;
        rstn_i = 1'b0;
        #1;
        check_val("arst_sum0", 32'(quota_sum[0]), 32'd0);
        check_val("arst_sum1", 32'(quota_sum[1]), 32'd0);
        check_val("arst_intr", 32'(intr_quota), 32'd0);
        check_val("arst_done", 32'(scan_done), 32'd0);
        step(2);
        rstn_i = 1'b1;
        step(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000 ns");
        $fatal(1);
    end

endmodule
